vga_timing_gen: RTL and testbench

- Pixel-timing stage that sits directly upstream of the video/audio top level.
- Produces hpos/vpos, hsync/vsync, display_on and a frame counter for the pattern logic.
- Replaces the separate sync generator and the top level's vsync-edge frame counter with one block.
- All outputs come from registers (glitch-free) and are cycle-aligned with each other.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_timing_if.sv | 23 ++
 rtl/vga_axis_timer.sv | 56 +++++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA pixel-timing block: 640x480@60 defaults,
// the position-counter width and the axis-total helper.
package vga_timing_pkg;

  localparam int POS_W = 10;
  localparam int POS_LIMIT = 1 << POS_W;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Pixel-timing bundle from the timing generator to the pattern/video logic.
interface vga_timing_if
  import vga_timing_pkg::*;
#(
  parameter int FRAME_BITS = 9
);
  logic [POS_W-1:0]      hpos;
  logic [POS_W-1:0]      vpos;
  logic                  hsync;
  logic                  vsync;
  logic                  display_on;
  logic                  line_start;
  logic                  frame_start;
  logic [FRAME_BITS-1:0] frame_no;

  modport master (
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_no
  );

  modport slave (
    input hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_no
  );
endinterface

// File: rtl/vga_axis_timer.sv
// One timing axis: a wrapping position counter with registered display,
// sync-window and last-position flags that line up with the position.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = DEF_H_DISPLAY,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [POS_W-1:0] pos,
  output logic             active,
  output logic             sync_act,
  output logic             at_last
);

  localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] DISP_END   = POS_W'(DISPLAY);
  localparam logic [POS_W-1:0] SYNC_FIRST = POS_W'(DISPLAY + FRONT);
  localparam logic [POS_W-1:0] SYNC_LAST  = POS_W'(DISPLAY + FRONT + SYNC - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             active_q, sync_q, last_q;

  always_comb begin
    pos_d = pos_q;
    if (advance) begin
      pos_d = last_q ? '0 : pos_q + 1'b1;
    end
  end

  // Flags are decoded from the next position so they land with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q    <= LAST;
      active_q <= 1'b0;
      sync_q   <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      pos_q    <= pos_d;
      active_q <= (pos_d < DISP_END);
      sync_q   <= (pos_d >= SYNC_FIRST) && (pos_d <= SYNC_LAST);
      last_q   <= (pos_d == LAST);
    end
  end

  assign pos      = pos_q;
  assign active   = active_q;
  assign sync_act = sync_q;
  assign at_last  = last_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: h/v counters, registered sync/display/start
// strobes and a frame counter, all aligned to the hpos/vpos they describe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = DEF_H_DISPLAY,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_DISPLAY  = DEF_V_DISPLAY,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit SYNC_NEG   = 1'b1,
  parameter int FRAME_BITS = 9
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vid
);

  if (axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK) > POS_LIMIT ||
      axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK) > POS_LIMIT) begin : g_bad_total
    $error("vga_timing_gen: line or frame total exceeds the position counter range");
  end

  localparam logic [POS_W-1:0] H_DISP_LAST = POS_W'(H_DISPLAY - 1);
  localparam logic [POS_W-1:0] H_SYNC_PRE  = POS_W'(H_DISPLAY + H_FRONT - 1);
  localparam logic [POS_W-1:0] H_SYNC_LAST = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [POS_W-1:0] V_DISP_LAST = POS_W'(V_DISPLAY - 1);
  localparam logic [POS_W-1:0] V_SYNC_PRE  = POS_W'(V_DISPLAY + V_FRONT - 1);
  localparam logic [POS_W-1:0] V_SYNC_LAST = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [POS_W-1:0] hpos, vpos;
  logic h_active, h_sync, h_last, v_active, v_sync, v_last;

  vga_axis_timer #(.DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)) u_h (
    .clk(clk), .reset(reset), .advance(1'b1),
    .pos(hpos), .active(h_active), .sync_act(h_sync), .at_last(h_last)
  );

  vga_axis_timer #(.DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)) u_v (
    .clk(clk), .reset(reset), .advance(h_last),
    .pos(vpos), .active(v_active), .sync_act(v_sync), .at_last(v_last)
  );

  logic h_act_nxt, v_act_nxt, h_sync_nxt, v_sync_nxt;
  logic disp_d, disp_q, hsync_d, hsync_q, vsync_d, vsync_q;
  logic line_d, line_q, fstart_d, fstart_q;
  logic [FRAME_BITS-1:0] frame_d, frame_q;

  // Predict each flag for the next position from the current one, so the
  // output registers present it in the same cycle as the counters.
  always_comb begin
    h_act_nxt  = h_last | (h_active & (hpos != H_DISP_LAST));
    h_sync_nxt = (hpos == H_SYNC_PRE) | (h_sync & (hpos != H_SYNC_LAST));
    v_act_nxt  = v_active;
    v_sync_nxt = v_sync;
    frame_d    = frame_q;
    if (h_last) begin
      v_act_nxt  = v_last | (v_active & (vpos != V_DISP_LAST));
      v_sync_nxt = (vpos == V_SYNC_PRE) | (v_sync & (vpos != V_SYNC_LAST));
      if (v_last) begin
        frame_d = frame_q + 1'b1;
      end
    end
    disp_d   = h_act_nxt & v_act_nxt;
    hsync_d  = h_sync_nxt ^ SYNC_NEG;
    vsync_d  = v_sync_nxt ^ SYNC_NEG;
    line_d   = h_last;
    fstart_d = h_last & v_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q   <= 1'b0;
      hsync_q  <= SYNC_NEG;
      vsync_q  <= SYNC_NEG;
      line_q   <= 1'b0;
      fstart_q <= 1'b0;
      frame_q  <= '1;
    end else begin
      disp_q   <= disp_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      line_q   <= line_d;
      fstart_q <= fstart_d;
      frame_q  <= frame_d;
    end
  end

  assign vid.hpos        = hpos;
  assign vid.vpos        = vpos;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.display_on  = disp_q;
  assign vid.line_start  = line_q;
  assign vid.frame_start = fstart_q;
  assign vid.frame_no    = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (active-low sync) and a
// tiny 16x11 instance (active-high sync, 2-bit frame counter) for whole frames.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  vga_timing_if #(.FRAME_BITS(9)) if_a ();
  vga_timing_if #(.FRAME_BITS(2)) if_b ();

  vga_timing_gen u_a (.clk(clk), .reset(rst_a), .vid(if_a));

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_NEG(1'b0), .FRAME_BITS(2)
  ) u_b (.clk(clk), .reset(rst_b), .vid(if_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_a_reset();
    check("a_rst_hpos", if_a.hpos, 799);
    check("a_rst_vpos", if_a.vpos, 524);
    check("a_rst_frame_no", if_a.frame_no, 9'h1ff);
    check("a_rst_display_on", if_a.display_on, 0);
    check("a_rst_hsync", if_a.hsync, 1);
    check("a_rst_vsync", if_a.vsync, 1);
    check("a_rst_line_start", if_a.line_start, 0);
    check("a_rst_frame_start", if_a.frame_start, 0);
  endtask

  task automatic check_b_reset();
    check("b_rst_hpos", if_b.hpos, 15);
    check("b_rst_vpos", if_b.vpos, 10);
    check("b_rst_frame_no", if_b.frame_no, 3);
    check("b_rst_display_on", if_b.display_on, 0);
    check("b_rst_hsync", if_b.hsync, 0);
    check("b_rst_vsync", if_b.vsync, 0);
    check("b_rst_line_start", if_b.line_start, 0);
    check("b_rst_frame_start", if_b.frame_start, 0);
  endtask

  // Expected default-instance outputs c cycles after reset release (first frame).
  task automatic check_a(input int c);
    int h, v;
    h = c % 800;
    v = c / 800;
    check("a_hpos", if_a.hpos, h);
    check("a_vpos", if_a.vpos, v);
    check("a_display_on", if_a.display_on, (h < 640 && v < 480) ? 1 : 0);
    check("a_hsync", if_a.hsync, (h >= 656 && h <= 751) ? 0 : 1);
    check("a_vsync", if_a.vsync, (v >= 490 && v <= 491) ? 0 : 1);
    check("a_line_start", if_a.line_start, (h == 0) ? 1 : 0);
    check("a_frame_start", if_a.frame_start, (c == 0) ? 1 : 0);
    check("a_frame_no", if_a.frame_no, 0);
  endtask

  // Expected tiny-instance outputs c cycles after reset release.
  task automatic check_b(input int c);
    int h, v, f;
    h = c % 16;
    v = (c / 16) % 11;
    f = (c / 176) % 4;
    check("b_hpos", if_b.hpos, h);
    check("b_vpos", if_b.vpos, v);
    check("b_display_on", if_b.display_on, (h < 8 && v < 6) ? 1 : 0);
    check("b_hsync", if_b.hsync, (h >= 10 && h <= 12) ? 1 : 0);
    check("b_vsync", if_b.vsync, (v >= 7 && v <= 8) ? 1 : 0);
    check("b_line_start", if_b.line_start, (h == 0) ? 1 : 0);
    check("b_frame_start", if_b.frame_start, (h == 0 && v == 0) ? 1 : 0);
    check("b_frame_no", if_b.frame_no, f);
  endtask

  initial begin
    int   hs_low, hs_first, hs_last, disp_fall, vs_run, vs_max, fs_cnt, found;
    logic disp_prev;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_a_reset();
    check_b_reset();

    // One full line plus the wrap onto line 1 on the default instance.
    rst_a     = 1'b0;
    hs_low    = 0;
    hs_first  = -1;
    hs_last   = -1;
    disp_fall = -1;
    disp_prev = 1'b0;
    for (int c = 0; c <= 800; c++) begin
      @(negedge clk);
      check_a(c);
      if (!if_a.hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(if_a.hpos);
        hs_last = int'(if_a.hpos);
      end
      if (disp_prev && !if_a.display_on) disp_fall = int'(if_a.hpos);
      disp_prev = if_a.display_on;
    end
    check("a_hsync_width", hs_low, 96);
    check("a_hsync_first", hs_first, 656);
    check("a_hsync_last", hs_last, 751);
    check("a_display_fall_hpos", disp_fall, 640);

    // Mid-line reset on the default instance.
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      if (if_a.hpos == 10'd300) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("a_reach_hpos300", found, 1);
    check("a_mid_vpos", if_a.vpos, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check_a_reset();
    rst_a = 1'b0;
    @(negedge clk);
    check_a(0);

    // Five whole frames on the tiny instance, through a frame_no wrap.
    rst_b  = 1'b0;
    vs_run = 0;
    vs_max = 0;
    fs_cnt = 0;
    exp_q  = {};
    for (int f = 1; f <= 5; f++) exp_q.push_back(2'(f));
    for (int c = 0; c <= 880; c++) begin
      @(negedge clk);
      check_b(c);
      if (if_b.vsync) begin
        vs_run++;
        if (vs_run > vs_max) vs_max = vs_run;
      end else begin
        vs_run = 0;
      end
      if (if_b.frame_start) begin
        fs_cnt++;
        if (c > 0) begin
          check("b_frame_q_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) check("b_frame_seq", if_b.frame_no, exp_q.pop_front());
        end
      end
    end
    check("b_vsync_width", vs_max, 32);
    check("b_frame_start_count", fs_cnt, 6);
    check("b_frame_q_left", exp_q.size(), 0);

    // Mid-frame reset on the tiny instance.
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      if (if_b.hpos == 10'd5 && if_b.vpos == 10'd4) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("b_reach_5_4", found, 1);
    check("b_mid_frame_no", if_b.frame_no, 1);
    rst_b = 1'b1;
    @(negedge clk);
    check_b_reset();
    rst_b = 1'b0;
    @(negedge clk);
    check_b(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
